// File: rtl/fifo_rr_scheduler_if.sv
// Bundle between the scheduler and its FIFO bank plus the downstream consumer.
// The master modport is the scheduler side.
interface fifo_rr_scheduler_if #(
    parameter int N_FIFO = 4,
    parameter int SIZE   = 8
);
    localparam int SRC_W = $clog2(N_FIFO);

    logic [N_FIFO-1:0]      F_EMPTY_N;
    logic [N_FIFO*SIZE-1:0] FIFO_DATA;
    logic [N_FIFO-1:0]      READ;
    logic [SIZE-1:0]        OUT_DATA;
    logic                   OUT_VALID;
    logic                   OUT_READY;
    logic [SRC_W-1:0]       OUT_SRC;
    logic                   OUT_LAST;

    modport master (
        input  F_EMPTY_N, FIFO_DATA, OUT_READY,
        output READ, OUT_DATA, OUT_VALID, OUT_SRC, OUT_LAST
    );

    modport slave (
        output F_EMPTY_N, FIFO_DATA, OUT_READY,
        input  READ, OUT_DATA, OUT_VALID, OUT_SRC, OUT_LAST
    );
endinterface

// File: rtl/fifo_rr_scheduler.sv
// Round-robin burst scheduler draining a bank of synchronous FIFOs onto one
// ready/valid stream. Each word costs ISSUE, CAPTURE and PRESENT cycles.
module fifo_rr_scheduler #(
    parameter int N_FIFO = 4,
    parameter int SIZE   = 8,
    parameter int BURST  = 4
) (
    input  logic              CLOCK,
    input  logic              RESET_N,
    input  logic              CLEAR_N,
    input  logic [N_FIFO-1:0] EN_MASK,
    output logic              BUSY,
    fifo_rr_scheduler_if.master bus
);
    localparam int PW = $clog2(N_FIFO);
    localparam int BW = $clog2(BURST + 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_PRESENT = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   grant_q, grant_d;
    logic [BW-1:0]   burst_q, burst_d;
    logic [SIZE-1:0] out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;
    logic [PW-1:0]   out_src_q, out_src_d;
    logic            out_last_q, out_last_d;

    logic [N_FIFO-1:0] cand;
    logic              found;
    logic [PW-1:0]     pick;
    logic [PW-1:0]     idx;
    logic [SIZE-1:0]   sel_word;
    logic              sel_avail;
    logic [BW-1:0]     burst_inc;
    logic [N_FIFO-1:0] read_vec;

    // First enabled, non-empty FIFO at or after ptr, wrapping around.
    always_comb begin
        cand  = EN_MASK & bus.F_EMPTY_N;
        found = 1'b0;
        pick  = ptr_q;
        idx   = '0;
        for (int i = 0; i < N_FIFO; i++) begin
            idx = PW'((int'(ptr_q) + i) % N_FIFO);
            if (!found && cand[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        sel_word  = '0;
        sel_avail = 1'b0;
        for (int i = 0; i < N_FIFO; i++) begin
            if (grant_q == PW'(i)) begin
                sel_word  = bus.FIFO_DATA[i*SIZE +: SIZE];
                sel_avail = bus.F_EMPTY_N[i];
            end
        end
        burst_inc = burst_q + BW'(1);
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        burst_d     = burst_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_src_d   = out_src_q;
        out_last_d  = out_last_q;
        if (!CLEAR_N) begin
            state_d     = ST_IDLE;
            ptr_d       = '0;
            grant_d     = '0;
            burst_d     = '0;
            out_data_d  = '0;
            out_valid_d = 1'b0;
            out_src_d   = '0;
            out_last_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (found) begin
                        grant_d = pick;
                        burst_d = '0;
                        state_d = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state_d = ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    // The FIFO's empty flag already accounts for the read just issued.
                    out_data_d  = sel_word;
                    out_src_d   = grant_q;
                    out_valid_d = 1'b1;
                    out_last_d  = (burst_inc == BW'(BURST)) || !sel_avail;
                    burst_d     = burst_inc;
                    state_d     = ST_PRESENT;
                end
                default: begin
                    if (bus.OUT_READY) begin
                        out_valid_d = 1'b0;
                        if (out_last_q) begin
                            ptr_d   = (grant_q == PW'(N_FIFO - 1)) ? '0 : grant_q + PW'(1);
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_ISSUE;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            burst_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_src_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            burst_q     <= burst_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_src_q   <= out_src_d;
            out_last_q  <= out_last_d;
        end
    end

    always_comb begin
        read_vec = '0;
        for (int i = 0; i < N_FIFO; i++) begin
            read_vec[i] = (state_q == ST_ISSUE) && (grant_q == PW'(i));
        end
    end

    assign bus.READ      = read_vec;
    assign BUSY          = (state_q != ST_IDLE);
    assign bus.OUT_DATA  = out_data_q;
    assign bus.OUT_VALID = out_valid_q;
    assign bus.OUT_SRC   = out_src_q;
    assign bus.OUT_LAST  = out_last_q;
endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Scoreboard bench: behavioural FIFO bank, queue-based round-robin reference
// model, and a monitor that checks every handshaked word.
module tb_fifo_rr_scheduler;
    localparam int N = 4;
    localparam int W = 8;
    localparam int B = 4;
    localparam int SW = 2;
    localparam int DEPTH = 256;
    localparam int RDY_HIGH = 0;
    localparam int RDY_RAND = 1;
    localparam int RDY_LOW  = 2;

    typedef struct {
        logic [W-1:0]  data;
        logic [SW-1:0] src;
        logic          last;
    } exp_t;

    logic CLOCK = 1'b0;
    logic RESET_N;
    logic CLEAR_N;
    logic [N-1:0] EN_MASK;
    logic BUSY;

    fifo_rr_scheduler_if #(.N_FIFO(N), .SIZE(W)) bus();

    fifo_rr_scheduler #(.N_FIFO(N), .SIZE(W), .BURST(B)) dut (
        .CLOCK  (CLOCK),
        .RESET_N(RESET_N),
        .CLEAR_N(CLEAR_N),
        .EN_MASK(EN_MASK),
        .BUSY   (BUSY),
        .bus    (bus.master)
    );

    always #5 CLOCK = ~CLOCK;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [W-1:0]   mem [N][DEPTH];
    int             wr_cnt [N];
    int             rd_cnt [N];
    logic [N*W-1:0] fifo_dout = '0;
    logic [N-1:0]   en_n;

    logic [W-1:0] model_q [N][$];
    int           model_ptr = 0;
    exp_t         sb [$];

    int   ready_mode = RDY_LOW;
    bit   gap_check = 1'b0;
    int   last_read_cyc = -1;
    bit   held = 1'b0;
    exp_t hold_v;
    exp_t pop_v;

    // Registered-output synchronous FIFOs, as the real bank behaves.
    always @(posedge CLOCK) begin
        cyc <= cyc + 1;
        for (int i = 0; i < N; i++) begin
            if (bus.READ[i]) begin
                fifo_dout[i*W +: W] <= mem[i][rd_cnt[i] % DEPTH];
                rd_cnt[i] <= rd_cnt[i] + 1;
            end
        end
    end

    always_comb begin
        en_n = '0;
        for (int i = 0; i < N; i++) en_n[i] = (wr_cnt[i] != rd_cnt[i]);
    end

    assign bus.F_EMPTY_N = en_n;
    assign bus.FIFO_DATA = fifo_dout;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: bound expired or unexpected event", name);
    endtask

    // Drive OUT_READY for the coming edge, then judge what that edge will do.
    always @(negedge CLOCK) begin
        case (ready_mode)
            RDY_HIGH: bus.OUT_READY = 1'b1;
            RDY_RAND: bus.OUT_READY = ($urandom_range(0, 2) != 0);
            default:  bus.OUT_READY = 1'b0;
        endcase
        if (bus.OUT_VALID) begin
            if (held) begin
                checkOutput("hold_data", 32'(bus.OUT_DATA), 32'(hold_v.data));
                checkOutput("hold_src", 32'(bus.OUT_SRC), 32'(hold_v.src));
                checkOutput("hold_last", 32'(bus.OUT_LAST), 32'(hold_v.last));
            end
            if (bus.OUT_READY) begin
                held = 1'b0;
                if (sb.size() == 0) begin
                    failNow("unexpected_word");
                end else begin
                    pop_v = sb.pop_front();
                    checkOutput("out_data", 32'(bus.OUT_DATA), 32'(pop_v.data));
                    checkOutput("out_src", 32'(bus.OUT_SRC), 32'(pop_v.src));
                    checkOutput("out_last", 32'(bus.OUT_LAST), 32'(pop_v.last));
                end
            end else begin
                held = 1'b1;
                hold_v.data = bus.OUT_DATA;
                hold_v.src  = bus.OUT_SRC;
                hold_v.last = bus.OUT_LAST;
            end
        end else begin
            held = 1'b0;
        end
        if (bus.READ != '0) begin
            checkOutput("read_legal", 32'($onehot(bus.READ) && ((bus.READ & en_n) == bus.READ)), 32'd1);
            if (gap_check) begin
                if (last_read_cyc >= 0) checkOutput("read_gap", cyc - last_read_cyc, 3);
                last_read_cyc = cyc;
            end
        end
        if (!gap_check) last_read_cyc = -1;
    end

    task automatic pushWord(input int f, input logic [W-1:0] d);
        mem[f][wr_cnt[f] % DEPTH] = d;
        wr_cnt[f] = wr_cnt[f] + 1;
        model_q[f].push_back(d);
    endtask

    task automatic applyStimulus(input int f, input int n);
        for (int k = 0; k < n; k++) pushWord(f, W'($urandom));
    endtask

    // Reference: whole bursts chosen by round-robin over the queued contents.
    task automatic model_drain(input int max_bursts, input logic [N-1:0] mask);
        int g;
        int n;
        int idx;
        exp_t e;
        for (int b = 0; b < max_bursts; b++) begin
            g = -1;
            for (int k = 0; k < N; k++) begin
                idx = (model_ptr + k) % N;
                if (g < 0 && mask[idx] && model_q[idx].size() > 0) g = idx;
            end
            if (g < 0) break;
            n = (model_q[g].size() < B) ? model_q[g].size() : B;
            for (int j = 0; j < n; j++) begin
                e.data = model_q[g].pop_front();
                e.src  = SW'(g);
                e.last = (j == n - 1);
                sb.push_back(e);
            end
            model_ptr = (g + 1) % N;
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_valid"}, 32'(bus.OUT_VALID), 0);
        checkOutput({tag, "_data"}, 32'(bus.OUT_DATA), 0);
        checkOutput({tag, "_src"}, 32'(bus.OUT_SRC), 0);
        checkOutput({tag, "_last"}, 32'(bus.OUT_LAST), 0);
        checkOutput({tag, "_busy"}, 32'(BUSY), 0);
        checkOutput({tag, "_read"}, 32'(bus.READ), 0);
    endtask

    task automatic doReset();
        RESET_N = 1'b0;
        EN_MASK = '0;
        for (int i = 0; i < N; i++) begin
            wr_cnt[i] = rd_cnt[i];
            model_q[i].delete();
        end
        sb.delete();
        model_ptr = 0;
        repeat (2) @(posedge CLOCK);
        #1;
        checkResetOutputs("reset");
        RESET_N = 1'b1;
    endtask

    task automatic waitDrain(input int limit);
        int n = 0;
        while ((sb.size() != 0 || BUSY) && n < limit) begin
            @(posedge CLOCK);
            #1;
            n++;
        end
        if (n >= limit) failNow("drain_timeout");
    endtask

    task automatic waitValid(input int limit);
        int n = 0;
        do begin
            @(posedge CLOCK);
            #1;
            n++;
        end while (!bus.OUT_VALID && n < limit);
        if (!bus.OUT_VALID) failNow("valid_timeout");
    endtask

    task automatic waitRead(input logic [N-1:0] which, input int limit);
        int n = 0;
        do begin
            @(posedge CLOCK);
            #1;
            n++;
        end while ((bus.READ & which) == '0 && n < limit);
        if ((bus.READ & which) == '0) failNow("read_timeout");
    endtask

    task automatic startDrain(input logic [N-1:0] mask);
        EN_MASK = mask;
        model_drain(1000, mask);
        waitDrain(3000);
        EN_MASK = '0;
    endtask

    initial begin
        logic [W-1:0]  cap_data;
        logic [SW-1:0] cap_src;
        logic          cap_last;
        logic [N-1:0]  rmask;

        RESET_N = 1'b0;
        CLEAR_N = 1'b1;
        EN_MASK = '0;
        doReset();

        // Single FIFO, one short burst at full rate.
        pushWord(0, 8'hA1);
        pushWord(0, 8'hA2);
        pushWord(0, 8'hA3);
        ready_mode = RDY_HIGH;
        gap_check = 1'b1;
        startDrain(4'b0001);
        gap_check = 1'b0;
        checkOutput("single_reads", rd_cnt[0] - (wr_cnt[0] - 3), 3);
        checkOutput("single_idle_busy", 32'(BUSY), 0);

        // Round-robin with the burst cap.
        doReset();
        applyStimulus(0, 6);
        applyStimulus(1, 2);
        applyStimulus(2, 2);
        ready_mode = RDY_RAND;
        startDrain(4'b1111);

        // Backpressure.
        doReset();
        applyStimulus(0, 3);
        ready_mode = RDY_LOW;
        EN_MASK = 4'b0001;
        model_drain(1000, 4'b0001);
        waitValid(20);
        cap_data = bus.OUT_DATA;
        cap_src  = bus.OUT_SRC;
        cap_last = bus.OUT_LAST;
        for (int k = 0; k < 5; k++) begin
            @(posedge CLOCK);
            #1;
            checkOutput("bp_no_read", 32'(bus.READ), 0);
            checkOutput("bp_data", 32'(bus.OUT_DATA), 32'(cap_data));
            checkOutput("bp_src", 32'(bus.OUT_SRC), 32'(cap_src));
            checkOutput("bp_last", 32'(bus.OUT_LAST), 32'(cap_last));
        end
        ready_mode = RDY_HIGH;
        @(posedge CLOCK);
        #1;
        checkOutput("bp_valid_drop", 32'(bus.OUT_VALID), 0);
        checkOutput("bp_read_after", 32'(bus.READ), 32'h1);
        waitDrain(200);
        EN_MASK = '0;

        // Mask: FIFO1 never served, FIFO0 burst survives losing its enable.
        doReset();
        applyStimulus(0, 5);
        for (int i = 1; i < N; i++) applyStimulus(i, 3);
        ready_mode = RDY_HIGH;
        EN_MASK = 4'b1101;
        model_drain(1, 4'b1101);
        model_drain(1000, 4'b1100);
        waitValid(20);
        EN_MASK = 4'b1100;
        waitDrain(500);
        checkOutput("mask_fifo1_left", wr_cnt[1] - rd_cnt[1], 3);
        checkOutput("mask_fifo0_left", wr_cnt[0] - rd_cnt[0], 1);
        EN_MASK = '0;

        // Synchronous clear during CAPTURE.
        doReset();
        applyStimulus(1, 5);
        applyStimulus(2, 3);
        ready_mode = RDY_HIGH;
        EN_MASK = 4'b1111;
        model_drain(1, 4'b1111);
        waitRead(4'b0100, 200);
        @(posedge CLOCK);
        #1;
        CLEAR_N = 1'b0;
        @(posedge CLOCK);
        #1;
        checkOutput("clear_valid", 32'(bus.OUT_VALID), 0);
        checkOutput("clear_busy", 32'(BUSY), 0);
        checkOutput("clear_read", 32'(bus.READ), 0);
        checkOutput("clear_sb_empty", sb.size(), 0);
        CLEAR_N = 1'b1;
        // The read word is discarded, so the model restarts from what is left.
        for (int i = 0; i < N; i++) begin
            model_q[i].delete();
            for (int k = rd_cnt[i]; k < wr_cnt[i]; k++) model_q[i].push_back(mem[i][k % DEPTH]);
        end
        model_ptr = 0;
        model_drain(1000, 4'b1111);
        waitRead(4'b1111, 20);
        checkOutput("clear_regrant", 32'(bus.READ), 32'b0010);
        waitDrain(500);
        EN_MASK = '0;

        // Asynchronous reset between edges while a word is presented.
        doReset();
        pushWord(2, 8'h5A);
        pushWord(2, 8'hC3);
        ready_mode = RDY_LOW;
        EN_MASK = 4'b0100;
        model_drain(1, 4'b0100);
        waitValid(20);
        checkOutput("pre_reset_src", 32'(bus.OUT_SRC), 2);
        checkOutput("pre_reset_data", 32'(bus.OUT_DATA), 32'h5A);
        #2;
        RESET_N = 1'b0;
        #1;
        checkResetOutputs("async");
        doReset();

        // Randomized phases; ptr carries across phases.
        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < N; i++) applyStimulus(i, $urandom_range(0, 6));
            rmask = N'($urandom_range(1, 15));
            ready_mode = RDY_RAND;
            startDrain(rmask);
            @(posedge CLOCK);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fifo_rr_scheduler.md
# fifo_rr_scheduler

Round-robin read scheduler that drains up to N_FIFO instances of the team's synchronous FIFO onto one shared output stream with ready/valid backpressure. It drives each FIFO's READ, samples the FIFO's registered DATA_OUT, and grants each non-empty, enabled FIFO a burst of at most BURST words before moving to the next. It sits between a bank of per-channel FIFOs and a single downstream consumer such as a serializer or DMA port.

## Interface
- N_FIFO, 4: number of FIFOs served; 2..8.
- SIZE, 8: data word width; must equal the FIFOs' SIZE.
- BURST, 4: maximum words per grant; ≥1.
- CLOCK  in  1  rising-edge clock, shared with all FIFOs.
- RESET_N  in  1  asynchronous, active-low reset.
- CLEAR_N  in  1  synchronous, active-low clear; same effect as reset.
- EN_MASK  in  N_FIFO  per-FIFO enable; 0 excludes that FIFO from arbitration.
- F_EMPTY_N  in  N_FIFO  per-FIFO empty flag, low = empty.
- FIFO_DATA  in  N_FIFO×SIZE  packed DATA_OUT of every FIFO; FIFO i occupies bits [i*SIZE +: SIZE].
- READ  out  N_FIFO  per-FIFO read strobe, one-hot or zero.
- OUT_DATA  out  SIZE  registered output word.
- OUT_VALID  out  1  OUT_DATA valid.
- OUT_READY  in  1  consumer accepts the word when OUT_VALID && OUT_READY.
- OUT_SRC  out  $clog2(N_FIFO)  index of the FIFO that supplied OUT_DATA.
- OUT_LAST  out  1  high on the final word of a burst.
- BUSY  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, PRESENT.
- IDLE: candidates = EN_MASK & F_EMPTY_N. If none, stay. Otherwise grant g = the first candidate at or after pointer ptr, searching upward mod N_FIFO. Clear the burst counter and go to ISSUE.
- ISSUE: drive READ[g]=1 for exactly this cycle, then go to CAPTURE.
- CAPTURE: FIFO_DATA[g] now holds the word. Register OUT_DATA and set OUT_SRC=g. Increment the burst counter.
  - OUT_LAST = (burst counter+1 == BURST) || !F_EMPTY_N[g]. F_EMPTY_N already reflects the read in this cycle.
  - Go to PRESENT.
- PRESENT: hold OUT_VALID=1 with OUT_DATA/OUT_SRC/OUT_LAST stable until OUT_READY=1. On that handshake edge:
  - If OUT_LAST=0, go to ISSUE with the same g.
  - If OUT_LAST=1, set ptr=(g+1) mod N_FIFO and go to IDLE.
- A scheduler never reads an empty FIFO. READ is never asserted in IDLE, CAPTURE or PRESENT.
- EN_MASK is sampled only in IDLE. Deasserting it mid-burst does not cut the burst short.
- Burst counter width is $clog2(BURST+1). The counter never exceeds BURST.

## Timing
- Reset/clear values: state=IDLE, ptr=0, READ=0, OUT_DATA=0, OUT_VALID=0, OUT_SRC=0, OUT_LAST=0, BUSY=0.
- CLEAR_N low on a rising edge: same values as reset. CLEAR_N takes priority over all FSM activity.
- Mid-operation reset or clear abandons the burst. A word already read but not handshaked is discarded.
- Latency from a FIFO becoming non-empty, with the scheduler in IDLE at cycle 0:
  - READ high in cycle 1.
  - OUT_VALID high from cycle 3.
- Throughput with OUT_READY held high: one word per 3 cycles (ISSUE, CAPTURE, PRESENT).
- IDLE costs one extra cycle between bursts.
- OUT_VALID drops in the cycle after the handshake. It does not reassert earlier than 2 cycles later.
- Outputs other than READ and BUSY are registered. READ and BUSY are decoded from state only.

## Test plan
- Single FIFO: FIFO0 holds A1,A2,A3, BURST=4, OUT_READY=1.
  - Required: three READ[0] pulses 3 cycles apart.
  - Stream A1,A2,A3 with OUT_SRC=0, OUT_LAST only on A3, then IDLE with BUSY=0.
- Round-robin with burst cap: FIFO0 holds 6 words, FIFO1 and FIFO2 hold 2 words each, BURST=4.
  - Required order: FIFO0 ×4 (OUT_LAST on the 4th), FIFO1 ×2, FIFO2 ×2, then FIFO0 ×2.
- Backpressure: OUT_READY low for 5 cycles after OUT_VALID rises.
  - Required: OUT_DATA/OUT_SRC/OUT_LAST stable, no READ pulses.
  - Next READ pulse occurs exactly one cycle after the handshake.
- Mask: EN_MASK=4'b1101 with all FIFOs non-empty, ptr=0.
  - Required: FIFO1 is never granted.
  - Clearing EN_MASK[0] during FIFO0's burst still completes that burst.
- Clear mid-burst: CLEAR_N low during CAPTURE.
  - Required: next cycle OUT_VALID=0, state IDLE, ptr=0, READ=0.
  - The next grant goes to the lowest non-empty enabled FIFO.
- Async reset: RESET_N pulsed low mid-PRESENT, between clock edges.
  - Required: all outputs reach reset values immediately, without waiting for a clock edge.
